// File: rtl/stage_4_permutation.sv
// -----------------------------------------------------------------------------
// stage_4_permutation
//
// Purpose: stride permutation for stage 4 of a 1024-point streaming transform.
//   A frame is 32 vectors of 32 words, and element index i = 32*cycle + lane.
//   Output element j equals input element j with index bit 0 and index bit 5
//   exchanged. Bit 0 is the low lane bit and bit 5 is the low cycle bit, so the
//   block works on pairs of input cycles (2m, 2m+1).
//
// Ports:
//   clk                      rising-edge clock
//   rst                      asynchronous reset, active low
//   inData_0 .. inData_31    input vector, one word per lane
//   in_start                 high together with vector 0 of a frame
//   outData_0 .. outData_31  permuted output vector, registered
//   out_start                in_start delayed by two cycles, registered
//
// Latency is two cycles. Storage is one buffered vector plus the output
// register.
//   - Even cycle of a pair: the output register takes the odd output vector
//     of the previous pair, which sits in the buffer. The buffer then takes
//     the incoming vector.
//   - Odd cycle of a pair: both output vectors of the pair can be built. The
//     even one goes to the output register. The odd one replaces the buffer
//     contents, so it leaves one cycle later.
// The port list has exactly 32 lanes, so INPUT_PER_CYCLE must stay 32.
// -----------------------------------------------------------------------------
module stage_4_permutation #(
  parameter int DATA_WIDTH_PER_INPUT = 28,
  parameter int INPUT_PER_CYCLE      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_0,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_1,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_2,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_3,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_4,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_5,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_6,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_7,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_8,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_9,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_10,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_11,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_12,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_13,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_14,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_15,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_16,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_17,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_18,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_19,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_20,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_21,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_22,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_23,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_24,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_25,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_26,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_27,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_28,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_29,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_30,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_31,
  input  logic                            in_start,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_0,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_1,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_2,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_3,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_4,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_5,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_6,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_7,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_8,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_9,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_10,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_11,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_12,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_13,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_14,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_15,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_16,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_17,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_18,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_19,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_20,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_21,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_22,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_23,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_24,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_25,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_26,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_27,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_28,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_29,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_30,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_31,
  output logic                            out_start
);

  localparam int W = DATA_WIDTH_PER_INPUT;
  localparam int L = INPUT_PER_CYCLE;

  logic [W-1:0] in_w      [L];
  logic [W-1:0] buf_q     [L];
  logic [W-1:0] buf_d     [L];
  logic [W-1:0] out_q     [L];
  logic [W-1:0] out_d     [L];
  logic [W-1:0] pair_even [L];
  logic [W-1:0] pair_odd  [L];
  logic         phase_q;
  logic         phase_d;
  logic         phase_cur;
  logic [1:0]   start_dly_q;
  logic [1:0]   start_dly_d;

  assign in_w[0]  = inData_0;
  assign in_w[1]  = inData_1;
  assign in_w[2]  = inData_2;
  assign in_w[3]  = inData_3;
  assign in_w[4]  = inData_4;
  assign in_w[5]  = inData_5;
  assign in_w[6]  = inData_6;
  assign in_w[7]  = inData_7;
  assign in_w[8]  = inData_8;
  assign in_w[9]  = inData_9;
  assign in_w[10] = inData_10;
  assign in_w[11] = inData_11;
  assign in_w[12] = inData_12;
  assign in_w[13] = inData_13;
  assign in_w[14] = inData_14;
  assign in_w[15] = inData_15;
  assign in_w[16] = inData_16;
  assign in_w[17] = inData_17;
  assign in_w[18] = inData_18;
  assign in_w[19] = inData_19;
  assign in_w[20] = inData_20;
  assign in_w[21] = inData_21;
  assign in_w[22] = inData_22;
  assign in_w[23] = inData_23;
  assign in_w[24] = inData_24;
  assign in_w[25] = inData_25;
  assign in_w[26] = inData_26;
  assign in_w[27] = inData_27;
  assign in_w[28] = inData_28;
  assign in_w[29] = inData_29;
  assign in_w[30] = inData_30;
  assign in_w[31] = inData_31;

  // During the odd cycle of a pair, buf_q holds vector 2m and in_w holds
  // vector 2m+1. Each lane pair (2g, 2g+1) swaps its cross terms.
  for (genvar g = 0; g < L / 2; g++) begin : g_pair
    assign pair_even[2*g]   = buf_q[2*g];
    assign pair_even[2*g+1] = in_w[2*g];
    assign pair_odd[2*g]    = buf_q[2*g+1];
    assign pair_odd[2*g+1]  = in_w[2*g+1];
  end

  // A start forces the even phase in the same cycle. When that happens in the
  // middle of a pair, the half-collected pair is dropped.
  always_comb begin
    phase_cur   = in_start ? 1'b0 : phase_q;
    phase_d     = ~phase_cur;
    start_dly_d = {start_dly_q[0], in_start};
    out_d       = buf_q;
    buf_d       = in_w;
    if (phase_cur) begin
      out_d = pair_even;
      buf_d = pair_odd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q     <= 1'b0;
      start_dly_q <= 2'b00;
      for (int i = 0; i < L; i++) begin
        buf_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      phase_q     <= phase_d;
      start_dly_q <= start_dly_d;
      buf_q       <= buf_d;
      out_q       <= out_d;
    end
  end

  assign out_start  = start_dly_q[1];

  assign outData_0  = out_q[0];
  assign outData_1  = out_q[1];
  assign outData_2  = out_q[2];
  assign outData_3  = out_q[3];
  assign outData_4  = out_q[4];
  assign outData_5  = out_q[5];
  assign outData_6  = out_q[6];
  assign outData_7  = out_q[7];
  assign outData_8  = out_q[8];
  assign outData_9  = out_q[9];
  assign outData_10 = out_q[10];
  assign outData_11 = out_q[11];
  assign outData_12 = out_q[12];
  assign outData_13 = out_q[13];
  assign outData_14 = out_q[14];
  assign outData_15 = out_q[15];
  assign outData_16 = out_q[16];
  assign outData_17 = out_q[17];
  assign outData_18 = out_q[18];
  assign outData_19 = out_q[19];
  assign outData_20 = out_q[20];
  assign outData_21 = out_q[21];
  assign outData_22 = out_q[22];
  assign outData_23 = out_q[23];
  assign outData_24 = out_q[24];
  assign outData_25 = out_q[25];
  assign outData_26 = out_q[26];
  assign outData_27 = out_q[27];
  assign outData_28 = out_q[28];
  assign outData_29 = out_q[29];
  assign outData_30 = out_q[30];
  assign outData_31 = out_q[31];

endmodule

// File: tb/tb_stage_4_permutation.sv
module tb_stage_4_permutation;
  localparam int W = 28;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_start;
  logic [W-1:0] in_d  [N];
  logic [W-1:0] out_d [N];
  logic         out_start;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame contents and the input schedule: for each input cycle t, frame sf[t]
  // (-1 = idle), cycle within that frame sc[t], and whether in_start is driven.
  logic [W-1:0] fm  [4][N][N];
  int           sf  [200];
  int           sc  [200];
  bit           ss  [200];
  int           slen;
  logic [W-1:0] obs [200][N];

  always #5 clk = ~clk;

  stage_4_permutation #(.DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(N)) dut (
    .clk(clk), .rst(rst),
    .inData_0(in_d[0]),   .inData_1(in_d[1]),   .inData_2(in_d[2]),   .inData_3(in_d[3]),
    .inData_4(in_d[4]),   .inData_5(in_d[5]),   .inData_6(in_d[6]),   .inData_7(in_d[7]),
    .inData_8(in_d[8]),   .inData_9(in_d[9]),   .inData_10(in_d[10]), .inData_11(in_d[11]),
    .inData_12(in_d[12]), .inData_13(in_d[13]), .inData_14(in_d[14]), .inData_15(in_d[15]),
    .inData_16(in_d[16]), .inData_17(in_d[17]), .inData_18(in_d[18]), .inData_19(in_d[19]),
    .inData_20(in_d[20]), .inData_21(in_d[21]), .inData_22(in_d[22]), .inData_23(in_d[23]),
    .inData_24(in_d[24]), .inData_25(in_d[25]), .inData_26(in_d[26]), .inData_27(in_d[27]),
    .inData_28(in_d[28]), .inData_29(in_d[29]), .inData_30(in_d[30]), .inData_31(in_d[31]),
    .in_start(in_start),
    .outData_0(out_d[0]),   .outData_1(out_d[1]),   .outData_2(out_d[2]),   .outData_3(out_d[3]),
    .outData_4(out_d[4]),   .outData_5(out_d[5]),   .outData_6(out_d[6]),   .outData_7(out_d[7]),
    .outData_8(out_d[8]),   .outData_9(out_d[9]),   .outData_10(out_d[10]), .outData_11(out_d[11]),
    .outData_12(out_d[12]), .outData_13(out_d[13]), .outData_14(out_d[14]), .outData_15(out_d[15]),
    .outData_16(out_d[16]), .outData_17(out_d[17]), .outData_18(out_d[18]), .outData_19(out_d[19]),
    .outData_20(out_d[20]), .outData_21(out_d[21]), .outData_22(out_d[22]), .outData_23(out_d[23]),
    .outData_24(out_d[24]), .outData_25(out_d[25]), .outData_26(out_d[26]), .outData_27(out_d[27]),
    .outData_28(out_d[28]), .outData_29(out_d[29]), .outData_30(out_d[30]), .outData_31(out_d[31]),
    .out_start(out_start)
  );

  function automatic int swp(input int j);
    return (j & ~33) | ((j & 1) << 5) | ((j >> 5) & 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_start = 1'b0;
    for (int l = 0; l < N; l++) in_d[l] = '0;
  endtask

  task automatic fill_count(input int f, input int base);
    for (int c = 0; c < N; c++)
      for (int l = 0; l < N; l++) fm[f][c][l] = W'(base + 32 * c + l);
  endtask

  task automatic add_seg(input int f, input int n, input bit st);
    for (int c = 0; c < n; c++) begin
      sf[slen] = f;
      sc[slen] = c;
      ss[slen] = st && (c == 0);
      slen++;
    end
  endtask

  task automatic check_zero(input string name);
    int bad_l;
    bad_l = -1;
    for (int l = 0; l < N; l++) if (out_d[l] !== '0 && bad_l < 0) bad_l = l;
    n_checks++;
    if (bad_l >= 0) begin
      n_fail++;
      $display("FAIL %s lane %0d: got %h expected 0", name, bad_l, out_d[bad_l]);
    end
    n_checks++;
    if (out_start !== 1'b0) begin
      n_fail++;
      $display("FAIL %s out_start: got %b expected 0", name, out_start);
    end
  endtask

  task automatic check_obs(input string name, input int k, input int l, input logic [W-1:0] e);
    n_checks++;
    if (obs[k][l] !== e) begin
      n_fail++;
      $display("FAIL %s out cycle %0d lane %0d: got %0d expected %0d", name, k, l, obs[k][l], e);
    end
  endtask

  // Runs the current schedule. Output index k = t-2 must match the permutation
  // of frame sf[k] wherever its pair partner was fed in the same phase.
  task automatic run_sched(input string name);
    int k, f, c, s, bad_l;
    bit valid, exp_st;
    logic [W-1:0] e, bad_e, bad_g;
    for (int t = 0; t < slen + 2; t++) begin
      step();
      k = t - 2;
      exp_st = 1'b0;
      valid  = 1'b0;
      f = -1;
      c = 0;
      if (k >= 0 && k < slen) begin
        f = sf[k];
        c = sc[k];
        exp_st = ss[k];
        if (f >= 0) begin
          if (c % 2 == 0)
            valid = (k + 1 < slen) && sf[k+1] == f && sc[k+1] == c + 1 && !ss[k+1];
          else
            valid = (k >= 1) && sf[k-1] == f && sc[k-1] == c - 1 && !ss[k];
        end
        for (int l = 0; l < N; l++) obs[k][l] = out_d[l];
      end
      n_checks++;
      if (out_start !== exp_st) begin
        n_fail++;
        $display("FAIL %s out_start t=%0d: got %b expected %b", name, t, out_start, exp_st);
      end
      if (valid) begin
        n_checks++;
        bad_l = -1;
        bad_e = '0;
        bad_g = '0;
        for (int l = 0; l < N; l++) begin
          s = swp(32 * c + l);
          e = fm[f][s/32][s%32];
          if (out_d[l] !== e && bad_l < 0) begin
            bad_l = l;
            bad_e = e;
            bad_g = out_d[l];
          end
        end
        if (bad_l >= 0) begin
          n_fail++;
          $display("FAIL %s data frame %0d cycle %0d lane %0d: got %h expected %h",
                   name, f, c, bad_l, bad_g, bad_e);
        end
      end
      if (t < slen) begin
        in_start = ss[t];
        for (int l = 0; l < N; l++) in_d[l] = (sf[t] >= 0) ? fm[sf[t]][sc[t]][l] : '0;
      end else begin
        drive_idle();
      end
    end
    drive_idle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_start = 1'b1;
    for (int l = 0; l < N; l++) in_d[l] = W'(l + 100);
    #3;
    check_zero("reset_initial");
    step();
    step();
    check_zero("reset_held_clocked");
    drive_idle();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_zero("post_reset_idle");
    end
  endtask

  task automatic test_single_frame();
    fill_count(0, 0);
    slen = 0;
    add_seg(0, 32, 1'b1);
    run_sched("single_frame");
    check_obs("sf_c0", 0, 0, 0);
    check_obs("sf_c0", 0, 1, 32);
    check_obs("sf_c0", 0, 30, 30);
    check_obs("sf_c0", 0, 31, 62);
    check_obs("sf_c1", 1, 0, 1);
    check_obs("sf_c1", 1, 1, 33);
    check_obs("sf_c1", 1, 31, 63);
    check_obs("sf_c30", 30, 0, 960);
    check_obs("sf_c30", 30, 1, 992);
    check_obs("sf_c30", 30, 2, 962);
    check_obs("sf_c31", 31, 1, 993);
    check_obs("sf_c31", 31, 31, 1023);
  endtask

  task automatic test_back_to_back();
    fill_count(0, 0);
    fill_count(1, 1024);
    slen = 0;
    add_seg(0, 32, 1'b1);
    add_seg(1, 32, 1'b1);
    run_sched("back_to_back");
    check_obs("b2b_f1c0", 32, 0, 1024);
    check_obs("b2b_f1c0", 32, 1, 1056);
    check_obs("b2b_f1c31", 63, 31, 2047);
  endtask

  task automatic test_free_running();
    fill_count(0, 0);
    fill_count(2, 4000);
    slen = 0;
    add_seg(0, 32, 1'b1);
    add_seg(2, 6, 1'b0);
    run_sched("free_running");
    check_obs("free_c1", 33, 0, 4001);
  endtask

  task automatic test_mid_frame();
    fill_count(0, 0);
    fill_count(1, 1024);
    slen = 0;
    add_seg(0, 7, 1'b1);
    add_seg(1, 32, 1'b1);
    run_sched("mid_frame");
    check_obs("mid_new_c0", 7, 1, 1056);
    check_obs("mid_new_c1", 8, 0, 1025);
  endtask

  task automatic test_reset_mid_frame();
    fill_count(0, 0);
    for (int t = 0; t < 11; t++) begin
      step();
      n_checks++;
      if (out_start !== (t == 2)) begin
        n_fail++;
        $display("FAIL rst_mid out_start t=%0d: got %b expected %b", t, out_start, (t == 2));
      end
      if (t < 10) begin
        in_start = (t == 0);
        for (int l = 0; l < N; l++) in_d[l] = fm[0][t][l];
      end
    end
    #2;
    rst = 1'b0;
    #1;
    check_zero("rst_mid_async");
    step();
    drive_idle();
    step();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      check_zero("rst_mid_after");
    end
    // Reset while the start pulse is still inside the delay line.
    step();
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_zero("rst_pending_start");
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_zero("rst_pending_after");
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < N; c++)
        for (int l = 0; l < N; l++) fm[f][c][l] = W'($urandom);
    fm[0][0][0] = '1;
    fm[0][0][1] = '0;
    fm[1][5][7] = '1;
    fm[2][3][3] = '0;
    fm[3][31][31] = '1;
    slen = 0;
    for (int f = 0; f < 4; f++) add_seg(f, 32, 1'b1);
    run_sched("random");
    check_obs("rand_ones", 0, 0, 28'hFFFFFFF);
    check_obs("rand_zero", 1, 0, 28'h0);
    check_obs("rand_ones_last", 127, 31, 28'hFFFFFFF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_free_running();
    test_mid_frame();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stage_4_permutation.md
STAGE_4_PERMUTATION -- requirements
Module: stage_4_permutation

Interface
REQ-001 Parameter DATA_WIDTH_PER_INPUT, default 28, width of each data word.
REQ-002 Parameter INPUT_PER_CYCLE, default 32, words per cycle; the port list is fixed at 32 lanes, so only 32 is supported.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 inData_0 .. inData_31  input  DATA_WIDTH_PER_INPUT each  lane l of the current input vector.
REQ-006 in_start  input  1  one-cycle pulse, high in the same cycle as input vector 0 of a 1024-point frame.
REQ-007 outData_0 .. outData_31  output  DATA_WIDTH_PER_INPUT each  lane l of the permuted output vector.
REQ-008 out_start  output  1  one-cycle pulse, high in the same cycle as output vector 0 of a frame.

Function
REQ-009 A frame is 1024 words streamed as 32 consecutive vectors of 32 words; element index i = 32*c + l, where c is the cycle 0..31 and l is the lane 0..31.
REQ-010 The block shall implement the stage-4 stride permutation: output element j equals input element swap(j), where swap exchanges index bit 0 (lane bit 0) with index bit 5 (cycle bit 0).
REQ-011 Input cycles are processed in pairs (2m, 2m+1). For output cycle 2m: even lane l takes input(2m, l); odd lane l takes input(2m+1, l-1).
REQ-012 For output cycle 2m+1: even lane l takes input(2m, l+1); odd lane l takes input(2m+1, l).
REQ-013 Latency shall be exactly 2 cycles: output vector k appears 2 clk cycles after input vector k is presented.
REQ-014 out_start shall equal in_start delayed by exactly 2 cycles.
REQ-015 All outputs shall be registered.
REQ-016 A 1-bit phase flag selects the even/odd position within a pair; it is forced to even (0) in the cycle where in_start is high and toggles every cycle otherwise.
REQ-017 The datapath is free-running: with no new in_start, pairing continues with the established phase, and out_start stays low.
REQ-018 An in_start arriving mid-frame shall re-align the phase immediately; the partially buffered pair is discarded, and the new frame's output is still correct at latency 2.
REQ-019 Back-to-back frames, with in_start exactly 32 cycles apart, shall stream without gaps or bubbles.
REQ-020 Storage is limited to one buffered input vector plus the output register (about 2×32 words); no frame-sized memory.
REQ-021 Data words pass unmodified; no arithmetic is performed.

Reset
REQ-022 While rst=0, all outData_* and out_start shall be 0, the phase flag shall be even, and all buffers and in_start delay stages shall be cleared, asynchronously.
REQ-023 After rst deasserts, out_start shall not pulse until 2 cycles after the first in_start.
REQ-024 Asserting rst mid-frame shall abort the frame; no out_start shall be produced for it.

Verification
REQ-025 Reset, then in_start with inData[l] = 32c + l for c = 0..31 -> out_start exactly 2 cycles later; output cycle 0 = 0,32,2,34,...,30,62.
REQ-026 Same stimulus -> output cycle 1 = 1,33,3,35,...,31,63; output cycle 30 = 960,992,962,994,...; output cycle 31 = 961,993,...,1023.
REQ-027 Two back-to-back frames, the second with offset +1024 -> continuous correct output, with out_start pulses 32 cycles apart.
REQ-028 Second in_start issued at input cycle 7 of a frame -> phase re-aligns and the new frame's outputs match REQ-011/012 from its own vector 0.
REQ-029 rst asserted at cycle 10 of a frame -> outputs and out_start go to 0 immediately without waiting for clk, and no out_start follows.
REQ-030 Random 28-bit data over 4 frames against a software model of REQ-010 -> zero mismatches, with all-ones and zero words passed intact.
